// File: rtl/rvh_l1d_pkg.sv
// Shared L1D definitions: MSHR entry state encoding and default geometry.
package rvh_l1d_pkg;

   localparam int MSHR_N_DEFAULT           = 4;
   localparam int MSHR_LINE_ADDR_W_DEFAULT = 50;

   typedef enum logic [1:0] {
      MSHR_IDLE = 2'd0,
      MSHR_REQ  = 2'd1,
      MSHR_WAIT = 2'd2
   } mshr_state_e;

endpackage

// File: rtl/priority_encoder.sv
// Lowest-index-first priority encoder; idx is 0 when no request is set.
module priority_encoder #(
   parameter int N = 4,
   parameter int W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0] req,
   output logic         vld,
   output logic [W-1:0] idx
);

   // scan from the top so the lowest set bit wins
   always_comb begin
      vld = 1'b0;
      idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         vld = vld | req[i];
         idx = req[i] ? W'(i) : idx;
      end
   end

endmodule

// File: rtl/rvh_l1d_mshr_alloc.sv
// Free-entry selection and free-entry count from the per-entry busy vector.
module rvh_l1d_mshr_alloc #(
   parameter int N    = 4,
   parameter int ID_W = $clog2(N)
) (
   input  logic [N-1:0]  busy,
   output logic          any_free,
   output logic [ID_W-1:0] free_id,
   output logic [ID_W:0] free_num
);

   priority_encoder #(.N(N), .W(ID_W)) u_free_pe (
      .req (~busy),
      .vld (any_free),
      .idx (free_id)
   );

   // popcount of idle entries
   always_comb begin
      free_num = '0;
      for (int i = 0; i < N; i++) begin
         free_num = free_num + {{ID_W{1'b0}}, ~busy[i]};
      end
   end

endmodule

// File: rtl/rvh_l1d_mshr_file.sv
// L1D miss status holding registers: allocation, secondary-miss lookup,
// L2 refill request issue and refill completion tracking.
module rvh_l1d_mshr_file
   import rvh_l1d_pkg::*;
#(
   parameter int N_MSHR      = MSHR_N_DEFAULT,
   parameter int LINE_ADDR_W = MSHR_LINE_ADDR_W_DEFAULT,
   parameter int ID_W        = $clog2(N_MSHR)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   alloc_vld_i,
   input  logic [LINE_ADDR_W-1:0] alloc_line_addr_i,
   output logic                   alloc_rdy_o,
   output logic [ID_W-1:0]        alloc_id_o,
   input  logic [LINE_ADDR_W-1:0] lookup_line_addr_i,
   output logic                   lookup_hit_o,
   output logic [ID_W-1:0]        lookup_hit_id_o,
   output logic                   l2_req_vld_o,
   input  logic                   l2_req_rdy_i,
   output logic [ID_W-1:0]        l2_req_id_o,
   output logic [LINE_ADDR_W-1:0] l2_req_line_addr_o,
   input  logic                   refill_done_vld_i,
   input  logic [ID_W-1:0]        refill_done_id_i,
   output logic [ID_W:0]          free_mshr_num_o
);

   mshr_state_e            state_r [N_MSHR];
   logic [N_MSHR-1:0]      valid_r;
   logic [LINE_ADDR_W-1:0] addr_r  [N_MSHR];
   logic                   lock_vld_r;
   logic [ID_W-1:0]        lock_id_r;

   logic [N_MSHR-1:0] busy_s;
   logic [N_MSHR-1:0] req_s;
   logic [N_MSHR-1:0] hit_vec_s;
   logic              alloc_match_s;
   logic              any_free_s;
   logic [ID_W-1:0]   pe_req_id_s;
   logic              alloc_fire_s;
   logic              l2_fire_s;

   // per-entry status vectors and address compares
   always_comb begin
      alloc_match_s = 1'b0;
      for (int i = 0; i < N_MSHR; i++) begin
         busy_s[i]     = (state_r[i] != MSHR_IDLE);
         req_s[i]      = (state_r[i] == MSHR_REQ);
         hit_vec_s[i]  = valid_r[i] & (addr_r[i] == lookup_line_addr_i);
         alloc_match_s = alloc_match_s | (valid_r[i] & (addr_r[i] == alloc_line_addr_i));
      end
   end

   rvh_l1d_mshr_alloc #(.N(N_MSHR), .ID_W(ID_W)) u_alloc (
      .busy     (busy_s),
      .any_free (any_free_s),
      .free_id  (alloc_id_o),
      .free_num (free_mshr_num_o)
   );

   priority_encoder #(.N(N_MSHR), .W(ID_W)) u_l2_pe (
      .req (req_s),
      .vld (l2_req_vld_o),
      .idx (pe_req_id_s)
   );

   priority_encoder #(.N(N_MSHR), .W(ID_W)) u_lookup_pe (
      .req (hit_vec_s),
      .vld (lookup_hit_o),
      .idx (lookup_hit_id_o)
   );

   // a stalled request stays pinned even if a lower entry enters REQ meanwhile
   assign l2_req_id_o        = lock_vld_r ? lock_id_r : pe_req_id_s;
   assign l2_req_line_addr_o = addr_r[l2_req_id_o];
   assign alloc_rdy_o        = any_free_s & ~alloc_match_s;
   assign alloc_fire_s       = alloc_vld_i & alloc_rdy_o;
   assign l2_fire_s          = l2_req_vld_o & l2_req_rdy_i;

   // request lock: remember the presented entry while the L2 stalls
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lock_vld_r <= 1'b0;
         lock_id_r  <= '0;
      end else begin
         lock_vld_r <= l2_req_vld_o & ~l2_req_rdy_i;
         lock_id_r  <= l2_req_id_o;
      end
   end

   // entry state machines; alloc only targets IDLE entries so arms never collide
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_r <= '0;
         for (int i = 0; i < N_MSHR; i++) begin
            state_r[i] <= MSHR_IDLE;
            addr_r[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < N_MSHR; i++) begin
            if (alloc_fire_s && (alloc_id_o == ID_W'(i))) begin
               state_r[i] <= MSHR_REQ;
               valid_r[i] <= 1'b1;
               addr_r[i]  <= alloc_line_addr_i;
            end else if (l2_fire_s && (l2_req_id_o == ID_W'(i))) begin
               state_r[i] <= MSHR_WAIT;
            end else if (refill_done_vld_i && (refill_done_id_i == ID_W'(i)) &&
                         (state_r[i] == MSHR_WAIT)) begin
               state_r[i] <= MSHR_IDLE;
               valid_r[i] <= 1'b0;
            end else begin
               state_r[i] <= state_r[i];
            end
         end
      end
   end

endmodule
